mc_dmem_ctrl: RTL



---
 rtl/mc_dmem_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mc_dmem_ctrl.sv
// mc_dmem_ctrl: handshaked CPU data memory with byte-lane writes; optional registered debug port (MC_DMEM_DBG_EN).
// Latency WAIT_CYC+2 cycles accept->ack; req is sampled only in IDLE, so changes while busy are ignored.
module mc_dmem_ctrl #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_W+1:0]     addr,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ack,
  output logic                  busy,
  input  logic [ADDR_W-1:0]     dbg_sel,
  output logic [DATA_W-1:0]     dbg_data
);

  localparam int        NB        = int'(DATA_W / 8);
  localparam int        DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_COMMIT} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [NB-1:0]       be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ack_q, ack_d;
  logic                busy_q, busy_d;

  // Byte offset bits select nothing in a word-organised array.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = we;
          idx_d   = addr[ADDR_W+1:2];
          be_d    = be;
          wdata_d = wdata;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYC != 0) ? ST_WAIT : ST_COMMIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (!we_q) rdata_d = mem[idx_q];
        ack_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  // Reset wins over a commit landing on the same edge.
  always_ff @(posedge clk) begin
    if (rstn && state_q == ST_COMMIT && we_q) begin
      for (int i = 0; i < NB; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign busy  = busy_q;

`ifdef MC_DMEM_DBG_EN
  logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
  assign dbg_data_d = mem[dbg_sel];

  always_ff @(posedge clk) begin
    if (!rstn) dbg_data_q <= '0;
    else       dbg_data_q <= dbg_data_d;
  end

  assign dbg_data = dbg_data_q;
`else
  logic unused_dbg_sel;
  assign unused_dbg_sel = ^dbg_sel;
  assign dbg_data       = '0;
`endif

endmodule
